// File: rtl/axil_dmem_slave.sv
// AXI4-Lite responder backed by a word-addressed synchronous RAM.
//
// Write path (AW/W/B) and read path (AR/R) run as independent FSMs. AW and W may
// arrive in any order; the write commits on the edge where the later of the two
// handshakes completes, honouring WSTRB byte lanes. Reads take one extra edge to
// access the RAM and return the pre-write word if a write to the same word
// commits on that edge.
//
// Ports:
//   CLK, NRST                     clock, synchronous active-low reset
//   AXI_AW*  / AXI_W*  / AXI_B*   write address, write data, write response
//   AXI_AR*  / AXI_R*             read address, read data/response
// Responses: OKAY (2'b00) in range, SLVERR (2'b10) outside
//   [BASE_ADDR, BASE_ADDR + MEM_DEPTH*4).
module axil_dmem_slave #(
   parameter int unsigned           AXI_AWIDTH = 32,
   parameter int unsigned           AXI_DWIDTH = 32,
   parameter int unsigned           MEM_DEPTH  = 1024,
   parameter logic [AXI_AWIDTH-1:0] BASE_ADDR  = '0,
   parameter string                 INIT_FILE  = ""
) (
   input  logic                    CLK,
   input  logic                    NRST,
   input  logic [AXI_AWIDTH-1:0]   AXI_AWADDR,
   input  logic                    AXI_AWVALID,
   output logic                    AXI_AWREADY,
   input  logic [AXI_DWIDTH-1:0]   AXI_WDATA,
   input  logic [AXI_DWIDTH/8-1:0] AXI_WSTRB,
   input  logic                    AXI_WVALID,
   output logic                    AXI_WREADY,
   output logic [1:0]              AXI_BRESP,
   output logic                    AXI_BVALID,
   input  logic                    AXI_BREADY,
   input  logic [AXI_AWIDTH-1:0]   AXI_ARADDR,
   input  logic                    AXI_ARVALID,
   output logic                    AXI_ARREADY,
   output logic [AXI_DWIDTH-1:0]   AXI_RDATA,
   output logic [1:0]              AXI_RRESP,
   output logic                    AXI_RVALID,
   input  logic                    AXI_RREADY
);

   localparam int unsigned           IdxW       = $clog2(MEM_DEPTH);
   localparam int unsigned           StrbW      = AXI_DWIDTH / 8;
   localparam logic [AXI_AWIDTH-1:0] MemBytes   = AXI_AWIDTH'(MEM_DEPTH * 4);
   localparam logic [1:0]            RespOkay   = 2'b00;
   localparam logic [1:0]            RespSlverr = 2'b10;

   typedef enum logic       {WIdle, WResp}        wr_state_e;
   typedef enum logic [1:0] {RIdle, RRead, RResp} rd_state_e;

   logic [AXI_DWIDTH-1:0] mem [MEM_DEPTH];

   // ---------------------------------------------------------------- write path
   wr_state_e             wst_q, wst_d;
   logic                  awready_q, awready_d;
   logic                  wready_q, wready_d;
   logic                  aw_got_q, aw_got_d;
   logic                  w_got_q, w_got_d;
   logic [AXI_AWIDTH-1:0] awaddr_q, awaddr_d;
   logic [AXI_DWIDTH-1:0] wdata_q, wdata_d;
   logic [StrbW-1:0]      wstrb_q, wstrb_d;
   logic                  bvalid_q, bvalid_d;
   logic [1:0]            bresp_q, bresp_d;

   logic                  aw_hs, w_hs;
   logic [AXI_AWIDTH-1:0] w_addr_sel, w_off;
   logic [AXI_DWIDTH-1:0] w_data_sel;
   logic [StrbW-1:0]      w_strb_sel;
   logic                  w_in_range;
   logic [IdxW-1:0]       w_idx;
   logic                  mem_we;

   assign aw_hs = AXI_AWVALID & awready_q;
   assign w_hs  = AXI_WVALID & wready_q;

   // A channel that handshakes this cycle is used directly; an earlier one comes
   // from its latch.
   assign w_addr_sel = aw_got_q ? awaddr_q : AXI_AWADDR;
   assign w_data_sel = w_got_q ? wdata_q : AXI_WDATA;
   assign w_strb_sel = w_got_q ? wstrb_q : AXI_WSTRB;
   assign w_off      = w_addr_sel - BASE_ADDR;
   assign w_in_range = (w_off < MemBytes);
   assign w_idx      = w_off[IdxW+1:2];

   always_comb begin
      wst_d     = wst_q;
      awready_d = awready_q;
      wready_d  = wready_q;
      aw_got_d  = aw_got_q;
      w_got_d   = w_got_q;
      awaddr_d  = awaddr_q;
      wdata_d   = wdata_q;
      wstrb_d   = wstrb_q;
      bvalid_d  = bvalid_q;
      bresp_d   = bresp_q;
      mem_we    = 1'b0;
      unique case (wst_q)
         WIdle: begin
            // Readies come up on the first cycle out of reset.
            if (aw_hs) begin
               aw_got_d  = 1'b1;
               awaddr_d  = AXI_AWADDR;
               awready_d = 1'b0;
            end else if (!aw_got_q) begin
               awready_d = 1'b1;
            end
            if (w_hs) begin
               w_got_d  = 1'b1;
               wdata_d  = AXI_WDATA;
               wstrb_d  = AXI_WSTRB;
               wready_d = 1'b0;
            end else if (!w_got_q) begin
               wready_d = 1'b1;
            end
            if ((aw_got_q || aw_hs) && (w_got_q || w_hs)) begin
               mem_we    = w_in_range;
               bvalid_d  = 1'b1;
               bresp_d   = w_in_range ? RespOkay : RespSlverr;
               aw_got_d  = 1'b0;
               w_got_d   = 1'b0;
               awready_d = 1'b0;
               wready_d  = 1'b0;
               wst_d     = WResp;
            end
         end
         WResp: begin
            if (AXI_BREADY) begin
               bvalid_d  = 1'b0;
               awready_d = 1'b1;
               wready_d  = 1'b1;
               wst_d     = WIdle;
            end
         end
      endcase
   end

   always_ff @(posedge CLK) begin
      if (!NRST) begin
         wst_q     <= WIdle;
         awready_q <= 1'b0;
         wready_q  <= 1'b0;
         aw_got_q  <= 1'b0;
         w_got_q   <= 1'b0;
         awaddr_q  <= '0;
         wdata_q   <= '0;
         wstrb_q   <= '0;
         bvalid_q  <= 1'b0;
         bresp_q   <= RespOkay;
      end else begin
         wst_q     <= wst_d;
         awready_q <= awready_d;
         wready_q  <= wready_d;
         aw_got_q  <= aw_got_d;
         w_got_q   <= w_got_d;
         awaddr_q  <= awaddr_d;
         wdata_q   <= wdata_d;
         wstrb_q   <= wstrb_d;
         bvalid_q  <= bvalid_d;
         bresp_q   <= bresp_d;
      end
   end

   // Memory array is deliberately not reset; a commit on a reset edge is dropped.
   always_ff @(posedge CLK) begin
      if (mem_we && NRST) begin
         for (int i = 0; i < int'(StrbW); i++) begin
            if (w_strb_sel[i]) mem[w_idx][8*i +: 8] <= w_data_sel[8*i +: 8];
         end
      end
   end

   // ----------------------------------------------------------------- read path
   rd_state_e             rst_q, rst_d;
   logic                  arready_q, arready_d;
   logic [AXI_AWIDTH-1:0] araddr_q, araddr_d;
   logic                  rvalid_q, rvalid_d;
   logic [AXI_DWIDTH-1:0] rdata_q, rdata_d;
   logic [1:0]            rresp_q, rresp_d;

   logic [AXI_AWIDTH-1:0] r_off;
   logic                  r_in_range;
   logic [IdxW-1:0]       r_idx;

   assign r_off      = araddr_q - BASE_ADDR;
   assign r_in_range = (r_off < MemBytes);
   assign r_idx      = r_off[IdxW+1:2];

   always_comb begin
      rst_d     = rst_q;
      arready_d = arready_q;
      araddr_d  = araddr_q;
      rvalid_d  = rvalid_q;
      rdata_d   = rdata_q;
      rresp_d   = rresp_q;
      case (rst_q)
         RIdle: begin
            if (AXI_ARVALID && arready_q) begin
               araddr_d  = AXI_ARADDR;
               arready_d = 1'b0;
               rst_d     = RRead;
            end else begin
               arready_d = 1'b1;
            end
         end
         RRead: begin
            // mem still holds pre-commit contents here, giving read-first collisions.
            rdata_d  = r_in_range ? mem[r_idx] : '0;
            rresp_d  = r_in_range ? RespOkay : RespSlverr;
            rvalid_d = 1'b1;
            rst_d    = RResp;
         end
         RResp: begin
            if (AXI_RREADY) begin
               rvalid_d  = 1'b0;
               arready_d = 1'b1;
               rst_d     = RIdle;
            end
         end
         default: rst_d = RIdle;
      endcase
   end

   always_ff @(posedge CLK) begin
      if (!NRST) begin
         rst_q     <= RIdle;
         arready_q <= 1'b0;
         araddr_q  <= '0;
         rvalid_q  <= 1'b0;
         rdata_q   <= '0;
         rresp_q   <= RespOkay;
      end else begin
         rst_q     <= rst_d;
         arready_q <= arready_d;
         araddr_q  <= araddr_d;
         rvalid_q  <= rvalid_d;
         rdata_q   <= rdata_d;
         rresp_q   <= rresp_d;
      end
   end

   // ------------------------------------------------------------------ outputs
   assign AXI_AWREADY = awready_q;
   assign AXI_WREADY  = wready_q;
   assign AXI_BVALID  = bvalid_q;
   assign AXI_BRESP   = bresp_q;
   assign AXI_ARREADY = arready_q;
   assign AXI_RVALID  = rvalid_q;
   assign AXI_RDATA   = rdata_q;
   assign AXI_RRESP   = rresp_q;

endmodule

// File: tb/tb_axil_dmem_slave.sv
// Directed bench for axil_dmem_slave. Expected responses are queued when a
// request is driven and popped when the DUT presents B or R. Inputs change and
// outputs are sampled on the falling clock edge.
module tb_axil_dmem_slave;

   logic        clk = 1'b0;
   logic        nrst = 1'b0;
   logic [31:0] awaddr = '0;
   logic        awvalid = 1'b0;
   logic        awready;
   logic [31:0] wdata = '0;
   logic [3:0]  wstrb = '0;
   logic        wvalid = 1'b0;
   logic        wready;
   logic [1:0]  bresp;
   logic        bvalid;
   logic        bready = 1'b1;
   logic [31:0] araddr = '0;
   logic        arvalid = 1'b0;
   logic        arready;
   logic [31:0] rdata;
   logic [1:0]  rresp;
   logic        rvalid;
   logic        rready = 1'b0;

   int n_cmp  = 0;
   int n_fail = 0;

   logic [1:0]  exp_b [$];
   logic [33:0] exp_r [$];  // {resp, data}

   always #5 clk = ~clk;

   axil_dmem_slave dut (
      .CLK         (clk),
      .NRST        (nrst),
      .AXI_AWADDR  (awaddr),
      .AXI_AWVALID (awvalid),
      .AXI_AWREADY (awready),
      .AXI_WDATA   (wdata),
      .AXI_WSTRB   (wstrb),
      .AXI_WVALID  (wvalid),
      .AXI_WREADY  (wready),
      .AXI_BRESP   (bresp),
      .AXI_BVALID  (bvalid),
      .AXI_BREADY  (bready),
      .AXI_ARADDR  (araddr),
      .AXI_ARVALID (arvalid),
      .AXI_ARREADY (arready),
      .AXI_RDATA   (rdata),
      .AXI_RRESP   (rresp),
      .AXI_RVALID  (rvalid),
      .AXI_RREADY  (rready)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %08h expected %08h", tag, obs, exp);
      end
   endtask

   // Present AW and W together; returns at the falling edge after both handshakes.
   task automatic send_write(input string tag, input logic [31:0] addr, input logic [31:0] data,
                             input logic [3:0] strb);
      bit aw_done = 1'b0;
      bit w_done  = 1'b0;
      bit aw_hs, w_hs;
      awaddr  = addr;
      awvalid = 1'b1;
      wdata   = data;
      wstrb   = strb;
      wvalid  = 1'b1;
      for (int c = 0; c < 20 && !(aw_done && w_done); c++) begin
         aw_hs = awvalid && awready;
         w_hs  = wvalid && wready;
         @(negedge clk);
         if (aw_hs) begin awvalid = 1'b0; aw_done = 1'b1; end
         if (w_hs)  begin wvalid = 1'b0;  w_done = 1'b1;  end
      end
      awvalid = 1'b0;
      wvalid  = 1'b0;
      check({tag, "_aw_w_hs"}, {30'd0, aw_done, w_done}, 32'd3);
   endtask

   // B must already be up right after the final handshake; bready assumed high.
   task automatic wait_b(input string tag);
      int lat = 0;
      logic [1:0] e;
      while (!bvalid && lat < 20) begin
         @(negedge clk);
         lat++;
      end
      check({tag, "_bvalid"}, bvalid, 1);
      check({tag, "_blat"}, lat, 0);
      e = (exp_b.size() > 0) ? exp_b.pop_front() : 2'bxx;
      check({tag, "_bresp"}, bresp, e);
      @(negedge clk);
      check({tag, "_bclr"}, bvalid, 0);
   endtask

   task automatic do_write(input string tag, input logic [31:0] addr, input logic [31:0] data,
                           input logic [3:0] strb, input logic [1:0] resp);
      exp_b.push_back(resp);
      send_write(tag, addr, data, strb);
      wait_b(tag);
   endtask

   task automatic send_read(input string tag, input logic [31:0] addr);
      bit done = 1'b0;
      bit hs;
      araddr  = addr;
      arvalid = 1'b1;
      for (int c = 0; c < 20 && !done; c++) begin
         hs = arvalid && arready;
         @(negedge clk);
         if (hs) begin arvalid = 1'b0; done = 1'b1; end
      end
      arvalid = 1'b0;
      check({tag, "_ar_hs"}, {31'd0, done}, 32'd1);
   endtask

   // RVALID is expected one falling edge after the AR handshake edge.
   task automatic wait_r(input string tag);
      int lat = 0;
      logic [33:0] e;
      while (!rvalid && lat < 20) begin
         @(negedge clk);
         lat++;
      end
      check({tag, "_rvalid"}, rvalid, 1);
      check({tag, "_rlat"}, lat, 1);
      e = (exp_r.size() > 0) ? exp_r.pop_front() : 34'bx;
      check({tag, "_rdata"}, rdata, e[31:0]);
      check({tag, "_rresp"}, rresp, {30'd0, e[33:32]});
      rready = 1'b1;
      @(negedge clk);
      rready = 1'b0;
      check({tag, "_rclr"}, rvalid, 0);
   endtask

   task automatic do_read(input string tag, input logic [31:0] addr, input logic [31:0] data,
                          input logic [1:0] resp);
      exp_r.push_back({resp, data});
      send_read(tag, addr);
      wait_r(tag);
   endtask

   initial begin
      logic [1:0]  eb;
      logic [33:0] er;

      // Reset values
      repeat (3) @(negedge clk);
      check("rst_awready", awready, 0);
      check("rst_wready", wready, 0);
      check("rst_arready", arready, 0);
      check("rst_bvalid", bvalid, 0);
      check("rst_rvalid", rvalid, 0);
      check("rst_bresp", bresp, 0);
      check("rst_rresp", rresp, 0);
      check("rst_rdata", rdata, 0);
      nrst = 1'b1;
      @(negedge clk);
      check("post_rst_awready", awready, 1);
      check("post_rst_wready", wready, 1);
      check("post_rst_arready", arready, 1);

      // Single write then read
      do_write("wr10", 32'h10, 32'hDEAD_BEEF, 4'hF, 2'b00);
      do_read("rd10", 32'h10, 32'hDEAD_BEEF, 2'b00);

      // W ahead of AW, commit only after AW, B held with BREADY low
      do_write("wr14_clear", 32'h14, 32'h0, 4'hF, 2'b00);
      exp_b.push_back(2'b00);
      bready = 1'b0;
      wdata  = 32'h1234_5678;
      wstrb  = 4'hF;
      wvalid = 1'b1;
      check("split_wready", wready, 1);
      @(negedge clk);
      wvalid = 1'b0;
      check("split_wready_drop", wready, 0);
      check("split_awready_hold", awready, 1);
      check("split_no_b0", bvalid, 0);
      do_read("split_precommit", 32'h14, 32'h0, 2'b00);
      check("split_no_b1", bvalid, 0);
      check("split_wready_low", wready, 0);
      awaddr  = 32'h14;
      awvalid = 1'b1;
      @(negedge clk);
      awvalid = 1'b0;
      eb = (exp_b.size() > 0) ? exp_b.pop_front() : 2'bxx;
      for (int i = 0; i < 4; i++) begin
         check("split_bhold_valid", bvalid, 1);
         check("split_bhold_resp", bresp, eb);
         check("split_bhold_awready", awready, 0);
         @(negedge clk);
      end
      bready = 1'b1;
      @(negedge clk);
      check("split_bclr", bvalid, 0);
      check("split_awready_back", awready, 1);
      check("split_wready_back", wready, 1);
      do_read("rd14", 32'h14, 32'h1234_5678, 2'b00);

      // Byte strobes
      do_write("wr20", 32'h20, 32'h1122_3344, 4'hF, 2'b00);
      do_write("wr20_strb5", 32'h20, 32'hAABB_CCDD, 4'b0101, 2'b00);
      do_read("rd20_strb5", 32'h20, 32'h11BB_33DD, 2'b00);
      do_write("wr20_strb0", 32'h20, 32'hFFFF_FFFF, 4'b0000, 2'b00);
      do_read("rd20_strb0", 32'h20, 32'h11BB_33DD, 2'b00);
      do_write("wr22_unaligned", 32'h22, 32'h0000_00EE, 4'b0001, 2'b00);
      do_read("rd20_unaligned", 32'h23, 32'h11BB_33EE, 2'b00);

      // Range boundaries
      do_write("wr0", 32'h0, 32'hCAFE_F00D, 4'hF, 2'b00);
      do_write("wr_oor", 32'h1000, 32'h0101_0101, 4'hF, 2'b10);
      do_read("rd0_alias", 32'h0, 32'hCAFE_F00D, 2'b00);
      do_read("rd_oor", 32'h1000, 32'h0, 2'b10);
      do_write("wr_last", 32'hFFC, 32'h5A5A_A5A5, 4'hF, 2'b00);
      do_read("rd_last", 32'hFFC, 32'h5A5A_A5A5, 2'b00);
      do_read("rd_wrap", 32'hFFFF_FFFC, 32'h0, 2'b10);

      // Collision: write to 0x30 commits on the R_READ edge of a 0x30 read
      do_write("wr30", 32'h30, 32'h5, 4'hF, 2'b00);
      exp_r.push_back({2'b00, 32'h5});
      exp_b.push_back(2'b00);
      araddr  = 32'h30;
      arvalid = 1'b1;
      check("col_arready", arready, 1);
      @(negedge clk);
      arvalid = 1'b0;
      awaddr  = 32'h30;
      wdata   = 32'h9;
      wstrb   = 4'hF;
      awvalid = 1'b1;
      wvalid  = 1'b1;
      check("col_awready", awready, 1);
      check("col_wready", wready, 1);
      @(negedge clk);
      awvalid = 1'b0;
      wvalid  = 1'b0;
      check("col_rvalid", rvalid, 1);
      check("col_bvalid", bvalid, 1);
      eb = (exp_b.size() > 0) ? exp_b.pop_front() : 2'bxx;
      check("col_bresp", bresp, eb);
      er = (exp_r.size() > 0) ? exp_r.pop_front() : 34'bx;
      for (int i = 0; i < 5; i++) begin
         check("col_rdata_stall", rdata, er[31:0]);
         check("col_rvalid_stall", rvalid, 1);
         @(negedge clk);
      end
      check("col_rresp", rresp, {30'd0, er[33:32]});
      rready = 1'b1;
      @(negedge clk);
      rready = 1'b0;
      check("col_rclr", rvalid, 0);
      do_read("rd30_new", 32'h30, 32'h9, 2'b00);

      // Reset with both channels holding responses
      bready = 1'b0;
      send_write("rst_wr40", 32'h40, 32'h77, 4'hF);
      send_read("rst_rd10", 32'h10);
      @(negedge clk);
      check("pre_rst_bvalid", bvalid, 1);
      check("pre_rst_rvalid", rvalid, 1);
      nrst = 1'b0;
      @(negedge clk);
      check("mid_rst_bvalid", bvalid, 0);
      check("mid_rst_rvalid", rvalid, 0);
      check("mid_rst_awready", awready, 0);
      check("mid_rst_wready", wready, 0);
      check("mid_rst_arready", arready, 0);
      nrst   = 1'b1;
      bready = 1'b1;
      @(negedge clk);
      check("rel_awready", awready, 1);
      check("rel_wready", wready, 1);
      check("rel_arready", arready, 1);
      check("rel_bvalid", bvalid, 0);
      do_read("rd40_persist", 32'h40, 32'h77, 2'b00);
      do_read("rd10_persist", 32'h10, 32'hDEAD_BEEF, 2'b00);

      check("sb_empty", exp_b.size() + exp_r.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: observed no completion expected completion before 500000");
      $fatal(1, "watchdog expired");
   end

endmodule
